reg_dump_ctrl: RTL and testbench
================================

REG_DUMP_CTRL -- requirements
Module: reg_dump_ctrl

Interface
REQ-001 The block SHALL have parameter DRAIN_CYCLES, default 4: number of stall cycles before the first register read, so in-flight writebacks complete.
REQ-002 The block SHALL have parameter NUM_REGS, default 32: registers dumped, indices 0..NUM_REGS-1.
REQ-003 The block SHALL have one clock and an asynchronous active-low reset, with ports as follows:
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
REQ-004 start  in  1  one-cycle request to begin a dump.
REQ-005 halt  in  1  pipeline halt flag; its rising edge also requests a dump.
REQ-006 reg_data  in  32  register-file read port A data; valid in the same cycle the address is driven, because the file is read at the falling edge.
REQ-007 tx_ready  in  1  byte sink ready.
REQ-008 db_stall  out  1  freezes the decode-stage pipeline register.
REQ-009 db_lector  out  1  selects debug address for read port A and suppresses register writes.
REQ-010 db_dirreg  out  5  debug register address.
REQ-011 tx_data  out  8  byte to sink.
REQ-012 tx_valid  out  1  tx_data valid.
REQ-013 busy  out  1  dump in progress.
REQ-014 done  out  1  one-cycle pulse when the final byte is accepted.

Function
REQ-015 The FSM SHALL have states IDLE, DRAIN, ADDR, SEND, FINISH.
REQ-016 IDLE SHALL go to DRAIN when start=1 or halt rises (halt=1 and the previous halt=0); the register index SHALL be cleared to 0 and the drain counter to DRAIN_CYCLES-1.
REQ-017 DRAIN SHALL decrement the drain counter each cycle and go to ADDR in the cycle after the counter reads 0, giving exactly DRAIN_CYCLES cycles; DRAIN_CYCLES=0 SHALL be treated as 1.
REQ-018 ADDR SHALL last exactly one cycle, driving db_lector=1 and db_dirreg=index, and SHALL load reg_data into a 32-bit shift register at the closing clock edge.
REQ-019 db_lector SHALL be 1 only in ADDR; db_dirreg SHALL be 0 outside ADDR.
REQ-020 SEND SHALL present shift[31:24] with tx_valid=1; a byte transfers on a cycle with tx_valid=1 and tx_ready=1.
REQ-021 On each transfer in SEND, the shift register SHALL shift left by 8 and the byte counter SHALL increment; register bytes go MSB first.
REQ-022 While tx_valid=1 and tx_ready=0, tx_data SHALL hold stable and tx_valid SHALL stay asserted.
REQ-023 After the 4th transfer, SEND SHALL go to ADDR with index+1, or to FINISH if index = NUM_REGS-1; the index SHALL never wrap.
REQ-024 FINISH SHALL last one cycle with done=1, then return to IDLE.
REQ-025 db_stall SHALL be 1 in DRAIN, ADDR, SEND and FINISH, and SHALL be 0 in IDLE.
REQ-026 busy SHALL equal the state being other than IDLE.
REQ-027 start and halt edges SHALL be ignored while busy; a request coinciding with FINISH SHALL be dropped.
REQ-028 halt held high SHALL trigger only one dump; halt SHALL be re-armed only after it falls.
REQ-029 A dump SHALL take DRAIN_CYCLES + NUM_REGS*(1+4) + 1 cycles when tx_ready is constantly 1: 165 cycles at the defaults.

Reset
REQ-030 Asserting rst_n=0 SHALL immediately force IDLE with all outputs 0, counters and the shift register 0, and the halt edge history 0.
REQ-031 Reset mid-dump SHALL abort without a done pulse and SHALL release db_stall asynchronously.
REQ-032 After reset release, the first request SHALL be accepted in the next cycle.

Structure
REQ-033 A shared debug package SHALL hold the state encoding, the byte-per-word constant 4, and register-address width 5.
REQ-034 No sub-module is needed; the block SHALL be a single FSM with its counters and shift register.

Verification
REQ-035 Pulse start with tx_ready=1 and the register file preset to R[i]=i*0x01010101 -> db_stall rises next cycle, 128 bytes arrive in the order 00 00 00 00 01 01 01 01 ..., done pulses at cycle 165, and busy then drops.
REQ-036 Drive halt 0->1 and hold it high for 500 cycles -> exactly one dump and one done pulse.
REQ-037 Toggle tx_ready randomly at 30% duty during SEND -> byte stream identical to REQ-035, with tx_data stable whenever tx_valid=1 and tx_ready=0.
REQ-038 Pulse start again at cycle 50 of a dump -> ignored: a single 128-byte stream and one done pulse.
REQ-039 Assert rst_n=0 during the SEND of register 7 -> db_stall, tx_valid and busy are 0 immediately, no done pulse, and a new start then dumps from register 0.
REQ-040 Set DRAIN_CYCLES=0 -> first ADDR occurs 2 cycles after start, and db_lector is 1 for exactly 32 cycles in total.

Source files
------------

// File: rtl/reg_dump_ctrl_pkg.sv
// Shared debug definitions for the register-dump controller:
// FSM state encoding, word/byte geometry and register address width.
package reg_dump_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRAIN  = 3'd1,
        ST_ADDR   = 3'd2,
        ST_SEND   = 3'd3,
        ST_FINISH = 3'd4
    } dump_state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int REG_ADDR_W     = 5;
    localparam int WORD_W         = 32;
    localparam int BYTE_W         = 8;

    // Bytes leave MSB first, so the outgoing byte is always the top of the word.
    function automatic logic [BYTE_W-1:0] top_byte(input logic [WORD_W-1:0] word);
        return word[WORD_W-1 -: BYTE_W];
    endfunction

endpackage

// File: rtl/reg_dump_ctrl.sv
// Register-file dump controller: stalls the pipeline, reads every register
// through debug read port A and streams each word out MSB-first, one byte at a time.
module reg_dump_ctrl
    import reg_dump_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 4,
    parameter int NUM_REGS     = 32
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  halt,
    input  logic [WORD_W-1:0]     reg_data,
    input  logic                  tx_ready,
    output logic                  db_stall,
    output logic                  db_lector,
    output logic [REG_ADDR_W-1:0] db_dirreg,
    output logic [BYTE_W-1:0]     tx_data,
    output logic                  tx_valid,
    output logic                  busy,
    output logic                  done
);

    localparam int DRAIN_W = 16;
    // A zero-length drain is stretched to one cycle so the FSM shape never changes.
    localparam logic [DRAIN_W-1:0]    DRAIN_INIT =
        (DRAIN_CYCLES <= 1) ? '0 : DRAIN_W'(DRAIN_CYCLES - 1);
    localparam logic [REG_ADDR_W-1:0] LAST_IDX  = REG_ADDR_W'(NUM_REGS - 1);
    localparam logic [1:0]            LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    dump_state_t           r_state;
    dump_state_t           w_nextState;
    logic                  r_haltPrev;
    logic [REG_ADDR_W-1:0] r_index;
    logic [DRAIN_W-1:0]    r_drainCnt;
    logic [1:0]            r_byteCnt;
    logic [WORD_W-1:0]     r_shift;

    logic w_request;
    logic w_xfer;
    logic w_lastByte;
    logic w_lastReg;

    assign w_request  = start | (halt & ~r_haltPrev);
    assign w_xfer     = (r_state == ST_SEND) & tx_ready;
    assign w_lastByte = (r_byteCnt == LAST_BYTE);
    assign w_lastReg  = (r_index == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        db_stall    = 1'b0;
        db_lector   = 1'b0;
        db_dirreg   = '0;
        tx_data     = '0;
        tx_valid    = 1'b0;
        done        = 1'b0;
        busy        = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                if (w_request) begin
                    w_nextState = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                db_stall = 1'b1;
                if (r_drainCnt == '0) begin
                    w_nextState = ST_ADDR;
                end
            end
            ST_ADDR: begin
                db_stall    = 1'b1;
                db_lector   = 1'b1;
                db_dirreg   = r_index;
                w_nextState = ST_SEND;
            end
            ST_SEND: begin
                db_stall = 1'b1;
                tx_valid = 1'b1;
                tx_data  = top_byte(r_shift);
                if (w_xfer && w_lastByte) begin
                    w_nextState = w_lastReg ? ST_FINISH : ST_ADDR;
                end
            end
            ST_FINISH: begin
                db_stall    = 1'b1;
                done        = 1'b1;
                w_nextState = ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Halt history is tracked in every state so a halt held through a dump
    // cannot retrigger once the FSM returns to idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_haltPrev <= 1'b0;
            r_index    <= '0;
            r_drainCnt <= '0;
            r_byteCnt  <= '0;
            r_shift    <= '0;
        end else begin
            r_haltPrev <= halt;
            case (r_state)
                ST_IDLE: begin
                    if (w_request) begin
                        r_index    <= '0;
                        r_drainCnt <= DRAIN_INIT;
                        r_byteCnt  <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (r_drainCnt != '0) begin
                        r_drainCnt <= r_drainCnt - 1'b1;
                    end
                end
                ST_ADDR: begin
                    r_shift   <= reg_data;
                    r_byteCnt <= '0;
                end
                ST_SEND: begin
                    if (w_xfer) begin
                        r_shift   <= {r_shift[WORD_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
                        r_byteCnt <= r_byteCnt + 1'b1;
                        if (w_lastByte && !w_lastReg) begin
                            r_index <= r_index + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump_ctrl.sv
// Self-checking bench for reg_dump_ctrl: a cycle table for the opening of a dump,
// then directed sequences for full dumps, halt, back-pressure, reset and zero drain.
module tb_reg_dump_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, halt, txReady, start2;
    logic [31:0] regData, regData2;
    logic        dbStall, dbLector, txValid, busy, done;
    logic [4:0]  dbDirreg;
    logic [7:0]  txData;
    logic        dbStall2, dbLector2, txValid2, busy2, done2;
    logic [4:0]  dbDirreg2;
    logic [7:0]  txData2;
    int          patternMode = 0;

    int compared   = 0;
    int mismatched = 0;

    function automatic logic [31:0] regValue(input int idx, input int mode);
        if (mode == 1) return 32'h11223344 + 32'(idx);
        return 32'(idx) * 32'h01010101;
    endfunction

    function automatic logic [7:0] expByte(input int k, input int mode);
        logic [31:0] w;
        w = regValue(k / 4, mode);
        return w[31 - 8 * (k % 4) -: 8];
    endfunction

    assign regData  = dbLector  ? regValue(int'(dbDirreg),  patternMode) : 32'hDEADBEEF;
    assign regData2 = dbLector2 ? regValue(int'(dbDirreg2), patternMode) : 32'hDEADBEEF;

    reg_dump_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .halt(halt),
        .reg_data(regData), .tx_ready(txReady),
        .db_stall(dbStall), .db_lector(dbLector), .db_dirreg(dbDirreg),
        .tx_data(txData), .tx_valid(txValid), .busy(busy), .done(done)
    );

    reg_dump_ctrl #(.DRAIN_CYCLES(0), .NUM_REGS(32)) dutZero (
        .clk(clk), .rst_n(rst_n), .start(start2), .halt(1'b0),
        .reg_data(regData2), .tx_ready(1'b1),
        .db_stall(dbStall2), .db_lector(dbLector2), .db_dirreg(dbDirreg2),
        .tx_data(txData2), .tx_valid(txValid2), .busy(busy2), .done(done2)
    );

    // Monitor: samples on the falling edge, away from state changes.
    logic [7:0] byteLog[$];
    int   cyc = 0;
    int   doneCount = 0, doneCount2 = 0, lectorCount2 = 0, stableErrors = 0, doneCyc = 0;
    logic prevHold = 1'b0;
    logic [7:0] prevData = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (txValid && txReady) byteLog.push_back(txData);
        if (prevHold && (!txValid || txData != prevData)) stableErrors++;
        prevHold = txValid && !txReady;
        prevData = txData;
        if (done) begin
            doneCount++;
            doneCyc = cyc;
        end
        if (done2) doneCount2++;
        if (dbLector2) lectorCount2++;
    end

    typedef struct {
        logic       start, halt, txReady;
        logic       stall, lector;
        logic [4:0] dir;
        logic       valid;
        logic [7:0] data;
        logic       busy, done;
    } vec_t;

    vec_t vecs[14];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v, input int row);
        start   = v.start;
        halt    = v.halt;
        txReady = v.txReady;
        stepCycle();
        checkOutput($sformatf("table row %0d", row),
                    64'({dbStall, dbLector, dbDirreg, txValid, txData, busy, done}),
                    64'({v.stall, v.lector, v.dir, v.valid, v.data, v.busy, v.done}));
    endtask

    task automatic waitDone(input int budget);
        int d0;
        bit ok;
        d0 = doneCount;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            stepCycle();
            if (doneCount != d0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) checkOutput("done timeout", 64'(0), 64'(1));
    endtask

    task automatic checkStream(input string name, input int base, input int mode);
        int n;
        n = byteLog.size() - base;
        checkOutput({name, " byte count"}, 64'(n), 64'(128));
        for (int k = 0; k < n && k < 128; k++)
            checkOutput($sformatf("%s byte %0d", name, k), 64'(byteLog[base + k]), 64'(expByte(k, mode)));
    endtask

    function automatic vec_t mk(input logic s, input logic h, input logic r,
                                input logic st, input logic le, input logic [4:0] di,
                                input logic va, input logic [7:0] da, input logic bu, input logic dn);
        vec_t v;
        v.start = s; v.halt = h; v.txReady = r;
        v.stall = st; v.lector = le; v.dir = di; v.valid = va; v.data = da; v.busy = bu; v.done = dn;
        return v;
    endfunction

    initial begin
        int base, d0, startCyc, l0, ok2;

        // Opening of a dump with R[i] = 0x11223344 + i, including stalls and ignored requests.
        vecs[0]  = mk(1, 0, 1,  1, 0, 5'd0, 0, 8'h00, 1, 0);
        vecs[1]  = mk(0, 0, 1,  1, 0, 5'd0, 0, 8'h00, 1, 0);
        vecs[2]  = mk(0, 0, 1,  1, 0, 5'd0, 0, 8'h00, 1, 0);
        vecs[3]  = mk(0, 0, 1,  1, 0, 5'd0, 0, 8'h00, 1, 0);
        vecs[4]  = mk(0, 0, 1,  1, 1, 5'd0, 0, 8'h00, 1, 0);
        vecs[5]  = mk(0, 0, 0,  1, 0, 5'd0, 1, 8'h11, 1, 0);
        vecs[6]  = mk(0, 0, 0,  1, 0, 5'd0, 1, 8'h11, 1, 0);
        vecs[7]  = mk(0, 0, 1,  1, 0, 5'd0, 1, 8'h22, 1, 0);
        vecs[8]  = mk(1, 0, 1,  1, 0, 5'd0, 1, 8'h33, 1, 0);
        vecs[9]  = mk(0, 0, 0,  1, 0, 5'd0, 1, 8'h33, 1, 0);
        vecs[10] = mk(0, 0, 1,  1, 0, 5'd0, 1, 8'h44, 1, 0);
        vecs[11] = mk(0, 0, 1,  1, 1, 5'd1, 0, 8'h00, 1, 0);
        vecs[12] = mk(1, 0, 1,  1, 0, 5'd0, 1, 8'h11, 1, 0);
        vecs[13] = mk(0, 1, 0,  1, 0, 5'd0, 1, 8'h11, 1, 0);

        patternMode = 1;
        rst_n = 1'b0; start = 1'b0; halt = 1'b0; txReady = 1'b1; start2 = 1'b0;
        repeat (3) stepCycle();
        checkOutput("reset outputs",
                    64'({dbStall, dbLector, dbDirreg, txValid, txData, busy, done}), 64'(0));
        checkOutput("reset outputs zero-drain",
                    64'({dbStall2, dbLector2, dbDirreg2, txValid2, txData2, busy2, done2}), 64'(0));
        rst_n = 1'b1;
        for (int i = 0; i < 14; i++) applyStimulus(vecs[i], i);

        // Abort the table dump with reset.
        rst_n = 1'b0; start = 1'b0; halt = 1'b0; txReady = 1'b1;
        #1;
        checkOutput("async reset busy", 64'({busy, dbStall}), 64'(0));
        repeat (2) stepCycle();
        rst_n = 1'b1;
        stepCycle();

        // Full dump with constant ready.
        patternMode = 0;
        base = byteLog.size();
        d0 = doneCount;
        start = 1'b1;
        stepCycle();
        startCyc = cyc;
        start = 1'b0;
        checkOutput("stall after start", 64'(dbStall), 64'(1));
        waitDone(400);
        checkOutput("busy after done", 64'(busy), 64'(0));
        checkOutput("done cycle", 64'(doneCyc - startCyc + 1), 64'(165));
        checkOutput("full dump done count", 64'(doneCount - d0), 64'(1));
        checkStream("full dump", base, 0);

        // Halt held high: one dump only.
        base = byteLog.size();
        d0 = doneCount;
        halt = 1'b1;
        repeat (500) stepCycle();
        halt = 1'b0;
        stepCycle();
        checkOutput("halt done count", 64'(doneCount - d0), 64'(1));
        checkOutput("halt byte count", 64'(byteLog.size() - base), 64'(128));

        // Random back-pressure at 30% ready.
        base = byteLog.size();
        d0 = doneCount;
        l0 = stableErrors;
        start = 1'b1;
        stepCycle();
        start = 1'b0;
        ok2 = 0;
        for (int i = 0; i < 3000; i++) begin
            txReady = ($urandom_range(0, 99) < 30);
            stepCycle();
            if (doneCount != d0) begin
                ok2 = 1;
                break;
            end
        end
        txReady = 1'b1;
        checkOutput("random ready completes", 64'(ok2), 64'(1));
        checkOutput("hold stability errors", 64'(stableErrors - l0), 64'(0));
        checkStream("random ready", base, 0);

        // Second start at cycle 50 is ignored.
        base = byteLog.size();
        d0 = doneCount;
        start = 1'b1;
        stepCycle();
        start = 1'b0;
        repeat (48) stepCycle();
        start = 1'b1;
        stepCycle();
        start = 1'b0;
        waitDone(400);
        repeat (200) stepCycle();
        checkOutput("restart done count", 64'(doneCount - d0), 64'(1));
        checkOutput("restart byte count", 64'(byteLog.size() - base), 64'(128));

        // Reset during the SEND of register 7.
        d0 = doneCount;
        start = 1'b1;
        stepCycle();
        start = 1'b0;
        ok2 = 0;
        for (int i = 0; i < 300; i++) begin
            stepCycle();
            if (dbLector && dbDirreg == 5'd7) begin
                ok2 = 1;
                break;
            end
        end
        checkOutput("reach register 7", 64'(ok2), 64'(1));
        stepCycle();
        checkOutput("sending register 7", 64'(txValid), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid-dump reset outputs", 64'({dbStall, txValid, busy}), 64'(0));
        repeat (3) stepCycle();
        rst_n = 1'b1;
        checkOutput("no done on abort", 64'(doneCount - d0), 64'(0));
        base = byteLog.size();
        start = 1'b1;
        stepCycle();
        start = 1'b0;
        waitDone(400);
        checkStream("after abort", base, 0);

        // Zero drain: ADDR two cycles after start, 32 reads in total.
        l0 = lectorCount2;
        d0 = doneCount2;
        start2 = 1'b1;
        stepCycle();
        start2 = 1'b0;
        checkOutput("zero drain cycle1 lector", 64'(dbLector2), 64'(0));
        stepCycle();
        checkOutput("zero drain cycle2 lector", 64'(dbLector2), 64'(1));
        ok2 = 0;
        for (int i = 0; i < 300; i++) begin
            stepCycle();
            if (doneCount2 != d0) begin
                ok2 = 1;
                break;
            end
        end
        checkOutput("zero drain completes", 64'(ok2), 64'(1));
        checkOutput("zero drain lector cycles", 64'(lectorCount2 - l0), 64'(32));
        checkOutput("zero drain done count", 64'(doneCount2 - d0), 64'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
